// File: rtl/pipe_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit_pkg
// Shared constants for the hazard/forwarding controller and the control unit.
//   - Stage indices as seen on the forward-select buses (0 = register file).
//   - Result-stage codes the control unit drives on id_res_stage.
//   - A helper that decides whether a matched writer can be forwarded yet.
// -----------------------------------------------------------------------------
package pipe_hazard_unit_pkg;

    localparam int STAGE_RF  = 0;
    localparam int STAGE_EXE = 1;
    localparam int STAGE_MEM = 2;
    localparam int STAGE_WB  = 3;

    // Result-stage codes: the stage whose combinational output first carries
    // the value. ALU results appear out of EXE, load data out of MEM.
    localparam int RES_ALU  = STAGE_EXE;
    localparam int RES_LOAD = STAGE_MEM;

    // A writer sitting in stage `p` can feed decode once the stage that
    // produces its result has been reached.
    function automatic logic stage_ready(input int p, input int res_stage);
        return (p >= res_stage);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit_match (operand_match)
// Searches the scoreboard for the youngest in-flight writer of one source
// register and reports whether its result can be forwarded yet.
// Ports:
//   src            in   source register address
//   used           in   source is actually read by the instruction
//   sb_valid       in   per-entry valid, entry i = instruction in stage i+1
//   sb_dst         in   flattened destination addresses, entry i at [i*W +: W]
//   sb_res         in   flattened result stages, entry i at [i*SEL_W +: SEL_W]
//   hit_not_ready  out  youngest writer exists but has no result yet
//   fwd_sel        out  0 = register file, k = result bus of stage k
// -----------------------------------------------------------------------------
module pipe_hazard_unit_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0]            src,
    input  logic                             used,
    input  logic [PIPE_DEPTH-1:0]            sb_valid,
    input  logic [PIPE_DEPTH*REG_ADDR_W-1:0] sb_dst,
    input  logic [PIPE_DEPTH*SEL_W-1:0]      sb_res,
    output logic                             hit_not_ready,
    output logic [SEL_W-1:0]                 fwd_sel
);

    logic found;

    // Scan from entry 0 upward; the first hit is the youngest writer and
    // masks any older writer of the same register further down the pipe.
    always_comb begin
        hit_not_ready = 1'b0;
        fwd_sel       = '0;
        found         = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (!found && used && (src != '0) && sb_valid[i] &&
                (sb_dst[i*REG_ADDR_W +: REG_ADDR_W] == src)) begin
                found = 1'b1;
                if (stage_ready(i + 1, int'(sb_res[i*SEL_W +: SEL_W]))) begin
                    fwd_sel = SEL_W'(i + 1);
                end else begin
                    hit_not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
// Decode-side hazard detection and forwarding control. Keeps a scoreboard of
// register writes in flight in the post-decode stages and, in the same cycle,
// produces the decode stall and per-operand forward selects.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   id_valid       in   decode holds a real instruction
//   id_rs, id_rt   in   decode source addresses
//   id_rs_used     in   rs actually read
//   id_rt_used     in   rt actually read
//   id_we          in   instruction writes a register
//   id_dst         in   destination address
//   id_res_stage   in   stage whose output first carries the result
//   flush          in   kill the instruction in decode this cycle
//   stall          out  hold PC and IF/ID, bubble into ID/EXE
//   fwd_rs_sel     out  forward select for rs (0 = register file)
//   fwd_rt_sel     out  forward select for rt (0 = register file)
//   stall_cnt      out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int PIPE_DEPTH  = 3,
    parameter int SEL_W       = $clog2(PIPE_DEPTH + 1),
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   id_we,
    input  logic [REG_ADDR_W-1:0]  id_dst,
    input  logic [SEL_W-1:0]       id_res_stage,
    input  logic                   flush,
    output logic                   stall,
    output logic [SEL_W-1:0]       fwd_rs_sel,
    output logic [SEL_W-1:0]       fwd_rt_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Scoreboard kept flattened so it shifts as plain vectors and feeds the
    // match blocks directly. Entry 0 sits in the low bits.
    logic [PIPE_DEPTH-1:0]            sb_valid;
    logic [PIPE_DEPTH*REG_ADDR_W-1:0] sb_dst;
    logic [PIPE_DEPTH*SEL_W-1:0]      sb_res;

    logic rs_not_ready;
    logic rt_not_ready;
    logic issue_write;

    pipe_hazard_unit_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_rs (
        .src           (id_rs),
        .used          (id_rs_used),
        .sb_valid      (sb_valid),
        .sb_dst        (sb_dst),
        .sb_res        (sb_res),
        .hit_not_ready (rs_not_ready),
        .fwd_sel       (fwd_rs_sel)
    );

    pipe_hazard_unit_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match_rt (
        .src           (id_rt),
        .used          (id_rt_used),
        .sb_valid      (sb_valid),
        .sb_dst        (sb_dst),
        .sb_res        (sb_res),
        .hit_not_ready (rt_not_ready),
        .fwd_sel       (fwd_rt_sel)
    );

    // Flush overrides any hazard: the instruction is being killed anyway.
    assign stall = id_valid & ~flush & (rs_not_ready | rt_not_ready);

    // Writes to register 0 are never tracked; a stalled or flushed
    // instruction leaves a bubble behind.
    assign issue_write = id_valid & id_we & (id_dst != '0) & ~stall & ~flush;

    // Post-decode stages never stall, so the scoreboard shifts every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid <= '0;
            sb_dst   <= '0;
            sb_res   <= '0;
        end else begin
            sb_valid <= {sb_valid[PIPE_DEPTH-2:0], issue_write};
            sb_dst   <= {sb_dst[(PIPE_DEPTH-1)*REG_ADDR_W-1:0], id_dst};
            sb_res   <= {sb_res[(PIPE_DEPTH-1)*SEL_W-1:0], id_res_stage};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

    localparam int RAW    = 5;
    localparam int PD     = 3;
    localparam int SW     = $clog2(PD + 1);
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic           clk;
    logic           rst;
    logic           id_valid;
    logic [RAW-1:0] id_rs;
    logic [RAW-1:0] id_rt;
    logic           id_rs_used;
    logic           id_rt_used;
    logic           id_we;
    logic [RAW-1:0] id_dst;
    logic [SW-1:0]  id_res_stage;
    logic           flush;
    logic           stall;
    logic [SW-1:0]  fwd_rs_sel;
    logic [SW-1:0]  fwd_rt_sel;
    logic [CW-1:0]  stall_cnt;

    pipe_hazard_unit #(
        .REG_ADDR_W  (RAW),
        .PIPE_DEPTH  (PD),
        .STALL_CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_we        (id_we),
        .id_dst       (id_dst),
        .id_res_stage (id_res_stage),
        .flush        (flush),
        .stall        (stall),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a list of in-flight writes, each tagged with how many
    // cycles it has been past decode (its stage number).
    typedef struct {
        int dst;
        int res;
        int age;
    } wr_t;

    wr_t inflight[$];
    int  m_cnt;
    bit  exp_stall;
    int  exp_rs;
    int  exp_rt;
    int  tests  = 0;
    int  failed = 0;

    function automatic void lookup(input int src, input bit used,
                                   output int sel, output bit not_ready);
        int best;
        best      = -1;
        sel       = 0;
        not_ready = 0;
        if (!used || src == 0) return;
        foreach (inflight[k]) begin
            if (inflight[k].dst == src &&
                (best < 0 || inflight[k].age < inflight[best].age)) best = k;
        end
        if (best < 0) return;
        if (inflight[best].age >= inflight[best].res) sel = inflight[best].age;
        else not_ready = 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic evaluate(input string tag);
        bit nr_rs;
        bit nr_rt;
        if (!rst) begin
            inflight.delete();
            m_cnt = 0;
        end
        lookup(int'(id_rs), id_rs_used, exp_rs, nr_rs);
        lookup(int'(id_rt), id_rt_used, exp_rt, nr_rt);
        exp_stall = id_valid && !flush && (nr_rs || nr_rt);
        check({tag, ".stall"},  {31'd0, stall}, {31'd0, exp_stall});
        check({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(exp_rs));
        check({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(exp_rt));
        check({tag, ".cnt"},    32'(stall_cnt),  32'(m_cnt));
    endtask

    task automatic apply(input bit v, input int rs, input int rt, input bit rsu,
                         input bit rtu, input bit we, input int dst, input int res,
                         input bit fl, input string tag);
        id_valid     = v;
        id_rs        = RAW'(rs);
        id_rt        = RAW'(rt);
        id_rs_used   = rsu;
        id_rt_used   = rtu;
        id_we        = we;
        id_dst       = RAW'(dst);
        id_res_stage = SW'(res);
        flush        = fl;
        #2;
        evaluate(tag);
    endtask

    task automatic tick();
        wr_t nxt[$];
        @(posedge clk);
        if (!rst) begin
            inflight.delete();
            m_cnt = 0;
        end else begin
            foreach (inflight[k]) begin
                if (inflight[k].age + 1 <= PD)
                    nxt.push_back('{inflight[k].dst, inflight[k].res, inflight[k].age + 1});
            end
            if (id_valid && id_we && id_dst != 0 && !exp_stall && !flush)
                nxt.push_back('{int'(id_dst), int'(id_res_stage), 1});
            inflight = nxt;
            if (exp_stall && m_cnt < CNTMAX) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
        tick();
    endtask

    initial begin
        clk = 0;
        rst = 0;

        // Reset holds everything quiet even with a live instruction in decode.
        apply(1, 3, 3, 1, 1, 1, 3, 1, 0, "reset");
        check("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1;
        for (int i = 0; i < 5; i++) idle("post_reset_idle");

        // ALU chain: 1-stage result forwards from EXE, then MEM.
        apply(1, 1, 2, 1, 1, 1, 3, 1, 0, "alu_producer");
        tick();
        apply(1, 3, 0, 1, 0, 0, 0, 0, 0, "alu_consumer_rs");
        check("alu_rs_sel", 32'(fwd_rs_sel), 32'd1);
        check("alu_rs_nostall", {31'd0, stall}, 32'd0);
        tick();
        apply(1, 0, 3, 0, 1, 0, 0, 0, 0, "alu_consumer_rt");
        check("alu_rt_sel", 32'(fwd_rt_sel), 32'd2);
        tick();

        // Load-use: one stall, then forward from MEM.
        apply(1, 0, 0, 0, 0, 1, 5, 2, 0, "load_producer");
        tick();
        apply(1, 5, 0, 1, 0, 1, 6, 1, 0, "load_use_stall");
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_sel0", 32'(fwd_rs_sel), 32'd0);
        tick();
        apply(1, 5, 0, 1, 0, 1, 6, 1, 0, "load_use_go");
        check("lu_go_stall", {31'd0, stall}, 32'd0);
        check("lu_go_sel", 32'(fwd_rs_sel), 32'd2);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Youngest writer wins.
        apply(1, 0, 0, 0, 0, 1, 7, 1, 0, "old_w7");
        tick();
        idle("gap");
        apply(1, 0, 0, 0, 0, 1, 7, 1, 0, "young_w7");
        tick();
        apply(1, 7, 7, 1, 1, 0, 0, 0, 0, "youngest");
        check("youngest_sel", 32'(fwd_rs_sel), 32'd1);
        check("rs_eq_rt", 32'(fwd_rt_sel), 32'd1);
        tick();

        // Register 0 is never a hazard.
        apply(1, 0, 0, 0, 0, 1, 0, 2, 0, "w0");
        tick();
        apply(1, 0, 0, 1, 1, 0, 0, 0, 0, "r0");
        check("r0_sel", 32'(fwd_rs_sel), 32'd0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        tick();

        // Flush beats a live load-use hazard and does not enter the scoreboard.
        apply(1, 0, 0, 0, 0, 1, 9, 2, 0, "flush_load");
        tick();
        apply(1, 9, 0, 1, 0, 1, 10, 1, 1, "flush_hazard");
        check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        apply(1, 10, 9, 1, 1, 0, 0, 0, 0, "after_flush");
        check("flush_bubble_sel", 32'(fwd_rs_sel), 32'd0);
        check("flush_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Saturation: 2 stalls per WB-result hazard, 10 hazards.
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 0, 0, 0, 1, 11, 3, 0, "sat_producer");
            tick();
            apply(1, 11, 0, 1, 0, 0, 0, 0, 0, "sat_consumer");
            tick();
            apply(1, 11, 0, 1, 0, 0, 0, 0, 0, "sat_consumer2");
            tick();
            apply(1, 11, 0, 1, 0, 0, 0, 0, 0, "sat_consumer3");
            tick();
        end
        check("sat_cnt", 32'(stall_cnt), 32'(CNTMAX));

        // Mid-operation async reset drops a pending hazard immediately.
        apply(1, 0, 0, 0, 0, 1, 12, 2, 0, "mid_load");
        tick();
        apply(1, 12, 0, 1, 0, 0, 0, 0, 0, "mid_hazard");
        check("mid_stall_before", {31'd0, stall}, 32'd1);
        rst = 0;
        #1;
        evaluate("mid_reset");
        check("mid_reset_stall", {31'd0, stall}, 32'd0);
        check("mid_reset_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst = 1;

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            bit v;
            bit we;
            v   = ($urandom_range(0, 9) != 0);
            we  = $urandom_range(0, 1);
            rst = ($urandom_range(0, 59) != 0);
            apply(v, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), we,
                  $urandom_range(0, 7), we ? $urandom_range(1, 3) : $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), "rand");
            tick();
        end
        rst = 1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
